// File: rtl/controle_janelas.sv
// controle_janelas: N_CH independent window channels. Each channel filters its
// light and humidity sensors, drives the open or close motor until the matching
// limit switch is reached, inserts an idle cycle on every direction reversal,
// and latches a fault on motor timeout or on both limit switches active at once.
module controle_janelas #(
  parameter int N_CH    = 4,
  parameter int DEB_CYC = 4,
  parameter int TIMEOUT = 100,
  parameter int TO_W    = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] CLARO,
  input  logic [N_CH-1:0] HUMIDADE,
  input  logic [N_CH-1:0] A,
  input  logic [N_CH-1:0] F,
  input  logic [N_CH-1:0] LIMPA,
  output logic [N_CH-1:0] ABRIR,
  output logic [N_CH-1:0] FECHAR,
  output logic [N_CH-1:0] FALHA
);

  // A one-cycle filter (DEB_CYC=1) still needs a 1-bit counter to stay legal.
  localparam int               CNT_W      = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEB_CYC - 1);
  localparam logic [TO_W-1:0]  TIMER_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_PARADO,
    ST_ABRINDO,
    ST_FECHANDO,
    ST_FALHA
  } state_t;

  state_t           state_q   [N_CH];
  state_t           state_d   [N_CH];
  logic [TO_W-1:0]  timer_q   [N_CH];
  logic [TO_W-1:0]  timer_d   [N_CH];
  logic [CNT_W-1:0] claro_cnt [N_CH];
  logic [CNT_W-1:0] hum_cnt   [N_CH];
  logic [N_CH-1:0]  claro_f;
  logic [N_CH-1:0]  hum_f;
  logic [N_CH-1:0]  fechar_req;
  logic [N_CH-1:0]  abrir_req;

  // Sensor debounce: a raw value must differ from the filtered one for
  // DEB_CYC consecutive edges before the filtered value follows it.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values regardless of statement order.
    if (RST) begin
      claro_f <= '0;
      hum_f   <= '0;
      // NOTE: these per-channel arrays are individual flops rather than a RAM,
      // so resetting every element is intended and cheap.
      for (int i = 0; i < N_CH; i++) begin
        claro_cnt[i] <= '0;
        hum_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (CLARO[i] == claro_f[i]) begin
          claro_cnt[i] <= '0;
        end else if (claro_cnt[i] == CNT_LAST) begin
          claro_f[i]   <= CLARO[i];
          claro_cnt[i] <= '0;
        end else begin
          claro_cnt[i] <= claro_cnt[i] + CNT_W'(1);
        end

        if (HUMIDADE[i] == hum_f[i]) begin
          hum_cnt[i] <= '0;
        end else if (hum_cnt[i] == CNT_LAST) begin
          hum_f[i]   <= HUMIDADE[i];
          hum_cnt[i] <= '0;
        end else begin
          hum_cnt[i] <= hum_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Either humidity or light asks for a closed window; otherwise open it.
  assign fechar_req = hum_f | claro_f;
  assign abrir_req  = ~hum_f & ~claro_f;

  // State and motion-timer registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_PARADO;
        timer_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

  // Next-state logic. The timer counts only while staying in a motion state,
  // so it is zero on every entry into ABRINDO/FECHANDO. Limit checks precede
  // the timeout check, so a limit hit on the last allowed cycle stops cleanly.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      // NOTE: defaults first so every path assigns and no latch is inferred.
      state_d[i] = state_q[i];
      timer_d[i] = '0;
      case (state_q[i])
        ST_PARADO: begin
          if (A[i] && F[i])                    state_d[i] = ST_FALHA;
          else if (fechar_req[i] && !F[i])     state_d[i] = ST_FECHANDO;
          else if (abrir_req[i] && !A[i])      state_d[i] = ST_ABRINDO;
        end
        ST_ABRINDO: begin
          if (A[i] && F[i])                    state_d[i] = ST_FALHA;
          else if (A[i])                       state_d[i] = ST_PARADO;
          else if (fechar_req[i])              state_d[i] = ST_PARADO;
          else if (timer_q[i] == TIMER_LAST)   state_d[i] = ST_FALHA;
          else                                 timer_d[i] = timer_q[i] + TO_W'(1);
        end
        ST_FECHANDO: begin
          if (A[i] && F[i])                    state_d[i] = ST_FALHA;
          else if (F[i])                       state_d[i] = ST_PARADO;
          else if (abrir_req[i])               state_d[i] = ST_PARADO;
          else if (timer_q[i] == TIMER_LAST)   state_d[i] = ST_FALHA;
          else                                 timer_d[i] = timer_q[i] + TO_W'(1);
        end
        ST_FALHA: begin
          if (LIMPA[i])                        state_d[i] = ST_PARADO;
        end
        default:                               state_d[i] = ST_PARADO;
      endcase
    end
  end

  // Moore outputs decoded straight from the state register.
  always_comb begin
    ABRIR  = '0;
    FECHAR = '0;
    FALHA  = '0;
    for (int i = 0; i < N_CH; i++) begin
      ABRIR[i]  = (state_q[i] == ST_ABRINDO);
      FECHAR[i] = (state_q[i] == ST_FECHANDO);
      FALHA[i]  = (state_q[i] == ST_FALHA);
    end
  end

endmodule

// File: tb/tb_controle_janelas.sv
// Bench for controle_janelas: a table of per-cycle vectors for reset, debounce
// and reversal, hand-written sequences for timeout, fault clear, limit conflict
// and mid-operation reset, then random stimulus against a behavioural model.
module tb_controle_janelas;

  localparam int N_CH    = 2;
  localparam int DEB_CYC = 4;
  localparam int TIMEOUT = 16;
  localparam int TO_W    = 8;
  localparam int N_ROWS  = 27;

  logic            clk;
  logic            rst;
  logic [N_CH-1:0] claro, hum, a, f, limpa;
  logic [N_CH-1:0] abrir, fechar, falha;

  int checks   = 0;
  int failures = 0;

  logic [N_CH-1:0] prev_abrir  = '0;
  logic [N_CH-1:0] prev_fechar = '0;

  // Behavioural model: a channel is idle, moving in a direction, or faulted;
  // m_driven counts cycles the motor has been driven in the current motion.
  bit m_moving   [N_CH];
  bit m_open_dir [N_CH];
  bit m_fault    [N_CH];
  int m_driven   [N_CH];
  // Sensor filter model: filtered value, last raw sample and how many
  // consecutive post-reset edges the raw input has held that sample.
  bit m_cf   [N_CH];
  bit m_hf   [N_CH];
  bit c_last [N_CH];
  bit h_last [N_CH];
  int c_run  [N_CH];
  int h_run  [N_CH];

  typedef struct packed {
    logic       rst;
    logic [1:0] claro;
    logic [1:0] hum;
    logic [1:0] a;
    logic [1:0] f;
    logic [1:0] limpa;
    logic [1:0] abrir;
    logic [1:0] fechar;
    logic [1:0] falha;
  } vec_t;

  vec_t tbl [N_ROWS];

  controle_janelas #(
    .N_CH   (N_CH),
    .DEB_CYC(DEB_CYC),
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .CLARO   (claro),
    .HUMIDADE(hum),
    .A       (a),
    .F       (f),
    .LIMPA   (limpa),
    .ABRIR   (abrir),
    .FECHAR  (fechar),
    .FALHA   (falha)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [1:0] c, input logic [1:0] h,
                              input logic [1:0] av, input logic [1:0] fv, input logic [1:0] l,
                              input logic [1:0] ab, input logic [1:0] fe, input logic [1:0] fa);
    vec_t v;
    v.rst = r; v.claro = c; v.hum = h; v.a = av; v.f = fv; v.limpa = l;
    v.abrir = ab; v.fechar = fe; v.falha = fa;
    return v;
  endfunction

  task automatic filter_model(input bit raw, inout bit filt, inout bit last, inout int run);
    if (run == 0 || raw != last) run = 1;
    else                         run++;
    last = raw;
    if (raw != filt && run >= DEB_CYC) filt = raw;
  endtask

  task automatic model_step();
    bit want_close, at_limit, wrong_way;
    for (int i = 0; i < N_CH; i++) begin
      if (rst) begin
        m_moving[i] = 0; m_open_dir[i] = 0; m_fault[i] = 0; m_driven[i] = 0;
        m_cf[i] = 0; m_hf[i] = 0; c_run[i] = 0; h_run[i] = 0;
      end else begin
        want_close = m_hf[i] | m_cf[i];
        if (m_fault[i]) begin
          if (limpa[i]) m_fault[i] = 0;
        end else if (a[i] && f[i]) begin
          m_fault[i]  = 1;
          m_moving[i] = 0;
        end else if (m_moving[i]) begin
          at_limit  = m_open_dir[i] ? a[i] : f[i];
          wrong_way = (m_open_dir[i] == want_close);
          if (at_limit || wrong_way) begin
            m_moving[i] = 0;
          end else if (m_driven[i] == TIMEOUT) begin
            m_moving[i] = 0;
            m_fault[i]  = 1;
          end else begin
            m_driven[i]++;
          end
        end else if (want_close && !f[i]) begin
          m_moving[i] = 1; m_open_dir[i] = 0; m_driven[i] = 1;
        end else if (!want_close && !a[i]) begin
          m_moving[i] = 1; m_open_dir[i] = 1; m_driven[i] = 1;
        end
        filter_model(claro[i], m_cf[i], c_last[i], c_run[i]);
        filter_model(hum[i],   m_hf[i], h_last[i], h_run[i]);
      end
    end
  endtask

  function automatic logic [1:0] exp_abrir();
    logic [1:0] v;
    for (int i = 0; i < N_CH; i++) v[i] = m_moving[i] & m_open_dir[i];
    return v;
  endfunction

  function automatic logic [1:0] exp_fechar();
    logic [1:0] v;
    for (int i = 0; i < N_CH; i++) v[i] = m_moving[i] & ~m_open_dir[i];
    return v;
  endfunction

  function automatic logic [1:0] exp_falha();
    logic [1:0] v;
    for (int i = 0; i < N_CH; i++) v[i] = m_fault[i];
    return v;
  endfunction

  // One clock: the model follows the edge, outputs are compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model_abrir",  8'(abrir),  8'(exp_abrir()));
    check("model_fechar", 8'(fechar), 8'(exp_fechar()));
    check("model_falha",  8'(falha),  8'(exp_falha()));
    check("no_overlap",   8'(abrir & fechar), 8'(0));
    check("no_direct_swap", 8'((prev_abrir & fechar) | (prev_fechar & abrir)), 8'(0));
    prev_abrir  = abrir;
    prev_fechar = fechar;
  endtask

  initial begin
    int count;

    //               rst  claro  hum    a      f      limpa  abrir  fechar falha
    tbl[0]  = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[1]  = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[2]  = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    tbl[3]  = mk(0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
    tbl[4]  = mk(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // humidity glitch of 3 cycles: no change
    tbl[5]  = mk(0, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[6]  = mk(0, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[7]  = mk(0, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[8]  = mk(0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // humidity held: filtered at the 4th edge, closing at the 5th
    tbl[9]  = mk(0, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[10] = mk(0, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[11] = mk(0, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[12] = mk(0, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[13] = mk(0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    tbl[14] = mk(0, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    // dry again while closed, then reopen
    tbl[15] = mk(0, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[16] = mk(0, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[17] = mk(0, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[18] = mk(0, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[19] = mk(0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    // light while opening: stop, one idle cycle, then close
    tbl[20] = mk(0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    tbl[21] = mk(0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    tbl[22] = mk(0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    tbl[23] = mk(0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    tbl[24] = mk(0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[25] = mk(0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    tbl[26] = mk(0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);

    for (int i = 0; i < N_CH; i++) begin
      m_moving[i] = 0; m_open_dir[i] = 0; m_fault[i] = 0; m_driven[i] = 0;
      m_cf[i] = 0; m_hf[i] = 0; c_last[i] = 0; h_last[i] = 0; c_run[i] = 0; h_run[i] = 0;
    end

    for (int r = 0; r < N_ROWS; r++) begin
      rst = tbl[r].rst; claro = tbl[r].claro; hum = tbl[r].hum;
      a = tbl[r].a; f = tbl[r].f; limpa = tbl[r].limpa;
      tick();
      check($sformatf("row%0d_abrir", r),  8'(abrir),  8'(tbl[r].abrir));
      check($sformatf("row%0d_fechar", r), 8'(fechar), 8'(tbl[r].fechar));
      check($sformatf("row%0d_falha", r),  8'(falha),  8'(tbl[r].falha));
    end

    // Timeout on channel 1: exactly TIMEOUT cycles of ABRIR, then fault.
    a = 2'b00; f = 2'b01; claro = 2'b01; hum = 2'b00; limpa = 2'b00;
    tick();
    check("timeout_entry_abrir", 8'(abrir), 8'(2'b10));
    count = abrir[1] ? 1 : 0;
    for (int k = 0; k < 40 && abrir[1]; k++) begin
      tick();
      if (abrir[1]) count++;
    end
    check("timeout_cycles", 8'(count), 8'(TIMEOUT));
    check("timeout_falha1", 8'(falha[1]), 8'(1));
    check("timeout_abrir1", 8'(abrir[1]), 8'(0));

    // The fault stays latched while channel 1 sensors move around.
    for (int k = 0; k < 10; k++) begin
      claro[1] = 1'($urandom_range(0, 1));
      hum[1]   = 1'($urandom_range(0, 1));
      tick();
    end
    claro[1] = 1'b0; hum[1] = 1'b0;
    for (int k = 0; k < DEB_CYC + 2; k++) tick();
    check("fault_latched", 8'(falha[1]), 8'(1));
    limpa = 2'b10;
    tick();
    check("clear_falha1", 8'(falha[1]), 8'(0));
    check("clear_idle1",  8'(abrir[1]), 8'(0));
    limpa = 2'b00;
    tick();
    check("reopen_abrir1", 8'(abrir[1]), 8'(1));
    a = 2'b10;
    tick();
    check("ch1_stopped", 8'(abrir), 8'(2'b00));

    // Limit conflict on channel 0 only.
    a = 2'b11; f = 2'b01;
    tick();
    check("conflict_falha", 8'(falha),  8'(2'b01));
    check("conflict_abrir", 8'(abrir),  8'(2'b00));
    check("conflict_fech",  8'(fechar), 8'(2'b00));

    // Bring channel 0 to FECHANDO and channel 1 to FALHA, then reset.
    limpa = 2'b01; a = 2'b10; f = 2'b00;
    tick();
    check("clear_falha0", 8'(falha), 8'(2'b00));
    limpa = 2'b00; f = 2'b10;
    tick();
    check("pre_reset_fechar", 8'(fechar), 8'(2'b01));
    check("pre_reset_falha",  8'(falha),  8'(2'b10));
    rst = 1'b1; claro = 2'b00; hum = 2'b01; a = 2'b11; f = 2'b00;
    tick();
    check("reset_abrir",  8'(abrir),  8'(0));
    check("reset_fechar", 8'(fechar), 8'(0));
    check("reset_falha",  8'(falha),  8'(0));
    rst = 1'b0;
    for (int k = 1; k <= DEB_CYC + 1; k++) begin
      tick();
      check($sformatf("post_reset_fechar_e%0d", k), 8'(fechar),
            8'((k == DEB_CYC + 1) ? 2'b01 : 2'b00));
    end

    // Random stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(0, 4) == 0) claro[i] = ~claro[i];
        if ($urandom_range(0, 7) == 0) hum[i]   = ~hum[i];
        a[i]     = ($urandom_range(0, 9) == 0);
        f[i]     = ($urandom_range(0, 9) == 0);
        limpa[i] = ($urandom_range(0, 11) == 0);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controle_janelas.md
Name: controle_janelas

Overview:
- Multi-channel, clocked successor of the combinational window open/close controller.
- Per channel it:
  - debounces the light (CLARO) and humidity (HUMIDADE) sensors;
  - runs a motor state machine driving ABRIR/FECHAR until the open (A) or closed (F) limit switch is hit;
  - enforces a one-cycle dead time on direction reversal;
  - flags a latched fault on motor timeout or inconsistent limit switches.
- Sits between the sensor/limit-switch inputs and the motor drivers. All inputs are synchronous to CLK.

Parameters:
- N_CH, 4, number of independent window channels.
- DEB_CYC, 4, consecutive stable cycles required before a filtered sensor value changes (>=1).
- TIMEOUT, 100, maximum cycles a motor may run before the channel faults (>=2).
- TO_W, 8, width of the per-channel motion timer; must satisfy 2^TO_W >= TIMEOUT.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- CLARO  in  N_CH  raw light sensor per channel (1 = light).
- HUMIDADE  in  N_CH  raw humidity sensor per channel (1 = humid).
- A  in  N_CH  open limit switch (1 = fully open).
- F  in  N_CH  closed limit switch (1 = fully closed).
- LIMPA  in  N_CH  fault clear per channel.
- ABRIR  out  N_CH  open-motor drive.
- FECHAR  out  N_CH  close-motor drive.
- FALHA  out  N_CH  latched fault flag.

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Channels are fully independent; every rule below applies per channel i.

Reset (RST=1 at a rising edge):
- state=PARADO, timer=0.
- Filtered CLARO_f=HUM_f=0; debounce counters 0.
- ABRIR=FECHAR=FALHA=0 from the following edge.
- RST mid-motion aborts immediately; RST overrides all other inputs.

Debounce (separately for CLARO and HUMIDADE):
- If raw == filtered: cnt<=0.
- Else cnt<=cnt+1; when cnt==DEB_CYC-1, filtered<=raw and cnt<=0.
- A change held DEB_CYC consecutive cycles updates filtered at the DEB_CYC-th edge. Any glitch back resets the count.

Requests (combinational from filtered values):
- fechar_req = HUM_f | CLARO_f.
- abrir_req = ~HUM_f & ~CLARO_f.
- Exactly one request is always active.

State machine: states PARADO, ABRINDO, FECHANDO, FALHA. Evaluate in priority order:
- PARADO:
  - A&F -> FALHA.
  - fechar_req & ~F -> FECHANDO.
  - abrir_req & ~A -> ABRINDO.
  - else stay.
- ABRINDO:
  - A&F -> FALHA.
  - A -> PARADO.
  - fechar_req -> PARADO (dead time; FECHANDO entered the next cycle via PARADO rules).
  - timer==TIMEOUT-1 -> FALHA.
  - else stay, timer+1.
- FECHANDO:
  - A&F -> FALHA.
  - F -> PARADO.
  - abrir_req -> PARADO.
  - timer==TIMEOUT-1 -> FALHA.
  - else stay, timer+1.
- FALHA:
  - LIMPA -> PARADO.
  - else stay. The fault is latched regardless of sensors.

Timer:
- Cleared on every entry into ABRINDO/FECHANDO.
- Motion therefore lasts at most TIMEOUT cycles.
- A limit reached in the same cycle as timeout wins (-> PARADO).

Outputs (Moore, decoded from the state register; change on the same edge as the state):
- ABRIR = (state==ABRINDO).
- FECHAR = (state==FECHANDO).
- FALHA = (state==FALHA).
- ABRIR and FECHAR are never both 1. A direct ABRIR->FECHAR swap without an intervening all-zero cycle never occurs.

Test Plan (N_CH=2, DEB_CYC=4, TIMEOUT=16):
1. Reset / auto-open: RST=1 for 2 cycles with all inputs 0 -> all outputs 0 during reset. On the first edge after RST=0, ABRIR=2'b11 (dark, dry, A=0). Set A[0]=1 -> ABRIR[0]=0 on the next edge; channel 1 keeps opening.
2. Debounce: channel 0 idle (A=1, F=0):
   - HUMIDADE[0] high for 3 cycles then low -> FECHAR[0] stays 0.
   - HUMIDADE[0] held high -> HUM_f=1 at the 4th edge, FECHAR[0]=1 at the 5th edge.
   - F[0]=1 -> FECHAR[0]=0 on the next edge.
3. Reversal dead time: channel 0 in ABRINDO; assert CLARO[0] for 4 cycles -> ABRIR[0] falls, then one cycle with ABRIR=FECHAR=0, then FECHAR[0]=1.
4. Timeout: channel 1 in ABRINDO with A[1]=0 held -> ABRIR[1]=1 for exactly 16 cycles, then FALHA[1]=1 and ABRIR[1]=0. The fault persists while sensors toggle; LIMPA[1] pulse -> PARADO, then ABRINDO on the next edge.
5. Limit conflict: A[0]=F[0]=1 in any non-fault state -> FALHA[0]=1 on the next edge; channel 1 outputs unaffected.
6. Reset mid-operation: RST=1 while channel 0 is in FECHANDO and channel 1 in FALHA -> all outputs 0 on the next edge. Debounce restarts from filtered 0, so a held HUMIDADE needs 4 fresh cycles.
